// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: stopwatch sequencer for the lab seven-segment display.
//   A tick prescaler drives a BCD digit counter. Start/stop, clear and lap
//   keys run a four-state control FSM (IDLE/RUN/LAP/PAUSE).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   key_ss, key_clr, key_lap   raw key levels (asynchronous to clk)
//   number                     registered BCD display value, digit 0 in [3:0]
//   dots                       constant one-hot dot enable at dot_pos
//   running                    high in RUN or LAP
//   lap_active                 high in LAP (display frozen on the snapshot)
//   tick                       one-cycle pulse, one cycle after each increment edge
//   overflow                   sticky wrap flag, cleared by clear in PAUSE
module stopwatch_ctrl #(
    parameter int clk_mhz  = 50,
    parameter int w_digit  = 8,
    parameter int tick_div = clk_mhz * 10000,
    parameter int dot_pos  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_ss,
    input  logic                 key_clr,
    input  logic                 key_lap,
    output logic [4*w_digit-1:0] number,
    output logic [w_digit-1:0]   dots,
    output logic                 running,
    output logic                 lap_active,
    output logic                 tick,
    output logic                 overflow
);

    localparam int PW = $clog2(tick_div);
    localparam logic [PW-1:0] PRE_LAST = PW'(tick_div - 1);
    localparam logic [w_digit-1:0] DOTS =
        (dot_pos >= 0 && dot_pos < w_digit) ? (w_digit'(1) << dot_pos) : '0;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_PAUSE} state_e;

    // Key bit order: [0]=ss, [1]=clr, [2]=lap
    logic [2:0] key_s1_q, key_s2_q, key_prev_q, press;

    state_e                state_q, state_d;
    logic [PW-1:0]         pre_q, pre_d;
    logic [4*w_digit-1:0]  bcd_q, bcd_d, snap_q, snap_d, number_q, number_d;
    logic [4*w_digit-1:0]  bcd_inc;
    logic                  tick_q, tick_d, ovf_q, ovf_d;
    logic                  carry;

    assign press = key_s2_q & ~key_prev_q;

    // Ripple-carry BCD increment; carry out of the top digit means all-9s.
    always_comb begin
        bcd_inc = bcd_q;
        carry   = 1'b1;
        for (int i = 0; i < w_digit; i++) begin
            if (carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        bcd_d   = bcd_q;
        snap_d  = snap_q;
        ovf_d   = ovf_q;
        tick_d  = 1'b0;

        // Counting is decided by the current state, so the edge that leaves
        // RUN/LAP still applies its increment.
        if (state_q == S_RUN || state_q == S_LAP) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                tick_d = 1'b1;
                bcd_d  = bcd_inc;
                if (carry) ovf_d = 1'b1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end

        // Priority ss > clr > lap; lower presses in the same cycle are dropped.
        unique case (state_q)
            S_IDLE: begin
                if (press[0]) begin
                    state_d = S_RUN;
                    pre_d   = '0;
                end
            end
            S_RUN: begin
                if (press[0]) begin
                    state_d = S_PAUSE;
                end else if (press[2]) begin
                    state_d = S_LAP;
                    snap_d  = bcd_q;
                end
            end
            S_LAP: begin
                if (press[0])      state_d = S_PAUSE;
                else if (press[2]) state_d = S_RUN;
            end
            S_PAUSE: begin
                if (press[0]) begin
                    state_d = S_RUN;
                end else if (press[1]) begin
                    state_d = S_IDLE;
                    bcd_d   = '0;
                    pre_d   = '0;
                    ovf_d   = 1'b0;
                    snap_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        number_d = (state_q == S_LAP) ? snap_q : bcd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q   <= '0;
            key_s2_q   <= '0;
            key_prev_q <= '0;
            state_q    <= S_IDLE;
            pre_q      <= '0;
            bcd_q      <= '0;
            snap_q     <= '0;
            number_q   <= '0;
            tick_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            key_s1_q   <= {key_lap, key_clr, key_ss};
            key_s2_q   <= key_s1_q;
            key_prev_q <= key_s2_q;
            state_q    <= state_d;
            pre_q      <= pre_d;
            bcd_q      <= bcd_d;
            snap_q     <= snap_d;
            number_q   <= number_d;
            tick_q     <= tick_d;
            ovf_q      <= ovf_d;
        end
    end

    assign number     = number_q;
    assign dots       = DOTS;
    assign running    = (state_q == S_RUN) || (state_q == S_LAP);
    assign lap_active = (state_q == S_LAP);
    assign tick       = tick_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with tick_div=4, w_digit=4, dot_pos=2.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Comments Ek name the k-th rising edge after the reference edge E0.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_ss, key_clr, key_lap;
    logic [15:0] number;
    logic [3:0]  dots;
    logic        running, lap_active, tick, overflow;

    int n_chk = 0;
    int n_err = 0;

    stopwatch_ctrl #(
        .clk_mhz (50),
        .w_digit (4),
        .tick_div(4),
        .dot_pos (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_ss    (key_ss),
        .key_clr   (key_clr),
        .key_lap   (key_lap),
        .number    (number),
        .dots      (dots),
        .running   (running),
        .lap_active(lap_active),
        .tick      (tick),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Assert keys at Ek+1, release at Ek+2+1, return at Ek+3+1 with the
    // resulting state visible.
    task automatic press(input logic ss, input logic clr, input logic lap);
        key_ss = ss; key_clr = clr; key_lap = lap;
        cyc(2);
        key_ss = 1'b0; key_clr = 1'b0; key_lap = 1'b0;
        cyc(1);
    endtask

    logic tick_seen;

    initial begin
        rst_n = 1'b1; key_ss = 1'b0; key_clr = 1'b0; key_lap = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_number", 32'(number), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_lap", 32'(lap_active), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("dots", 32'(dots), 32'h4);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);                                   // E0

        // Start: ss held 20 cycles, RUN from E3.
        key_ss = 1'b1;
        cyc(2);                                   // E2
        chk("start_not_yet", 32'(running), 32'h0);
        cyc(1);                                   // E3
        chk("start_running", 32'(running), 32'h1);
        cyc(3);                                   // E6
        chk("tick_e6", 32'(tick), 32'h0);
        cyc(1);                                   // E7: first wrap
        chk("tick_e7", 32'(tick), 32'h1);
        cyc(1);                                   // E8
        chk("tick_e8", 32'(tick), 32'h0);
        chk("num_e8", 32'(number), 32'h0001);
        cyc(3);                                   // E11
        chk("tick_e11", 32'(tick), 32'h1);
        cyc(9);                                   // E20
        key_ss = 1'b0;
        cyc(4);                                   // E24
        chk("held_ss_running", 32'(running), 32'h1);
        cyc(19);                                  // E43
        chk("num_e43", 32'(number), 32'h0009);
        cyc(1);                                   // E44: 10 increments
        chk("num_e44_carry", 32'(number), 32'h0010);

        // Lap freeze: LAP at E48, snapshot = 0x11.
        cyc(1);                                   // E45
        press(1'b0, 1'b0, 1'b1);                  // E48
        chk("lap_active", 32'(lap_active), 32'h1);
        chk("lap_running", 32'(running), 32'h1);
        cyc(12);                                  // E60, live = 14
        chk("lap_frozen", 32'(number), 32'h0011);
        cyc(1);                                   // E61
        press(1'b0, 1'b0, 1'b1);                  // E64 back to RUN
        chk("unlap_active", 32'(lap_active), 32'h0);
        cyc(1);                                   // E65
        chk("unlap_live", 32'(number), 32'h0015);

        // Pause: PAUSE at E68, increment to 16 at E67.
        press(1'b1, 1'b0, 1'b0);                  // E68
        chk("pause_running", 32'(running), 32'h0);
        cyc(1);                                   // E69
        chk("pause_num", 32'(number), 32'h0016);
        tick_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            tick_seen = tick_seen | tick;
        end                                       // E169
        chk("pause_no_tick", 32'(tick_seen), 32'h0);
        chk("pause_hold", 32'(number), 32'h0016);

        // ss+clr in PAUSE: RUN at E172, prescaler resumes from 1.
        press(1'b1, 1'b1, 1'b0);                  // E172
        chk("ssclr_running", 32'(running), 32'h1);
        chk("ssclr_not_cleared", 32'(number), 32'h0016);
        cyc(3);                                   // E175
        chk("resume_tick", 32'(tick), 32'h1);
        cyc(1);                                   // E176
        chk("resume_num", 32'(number), 32'h0017);

        // clr in RUN is ignored.
        press(1'b0, 1'b1, 1'b0);                  // E179
        chk("clr_run_running", 32'(running), 32'h1);
        cyc(1);                                   // E180
        chk("clr_run_num", 32'(number), 32'h0018);

        // ss+lap in RUN: PAUSE, lap dropped.
        press(1'b1, 1'b0, 1'b1);                  // E183
        chk("sslap_running", 32'(running), 32'h0);
        chk("sslap_lap", 32'(lap_active), 32'h0);
        cyc(1);                                   // E184
        chk("sslap_num", 32'(number), 32'h0019);

        // clr in PAUSE -> IDLE.
        press(1'b0, 1'b1, 1'b0);                  // E187
        chk("clr_idle_running", 32'(running), 32'h0);
        cyc(1);                                   // E188
        chk("clr_num", 32'(number), 32'h0);
        press(1'b0, 1'b0, 1'b1);                  // E191 lap ignored in IDLE
        chk("idle_lap_ignored", 32'(lap_active), 32'h0);

        // Wrap: RUN at E194, 10000th increment at E40194.
        press(1'b1, 1'b0, 1'b0);                  // E194
        cyc(39997);                               // E40191
        chk("pre_wrap_num", 32'(number), 32'h9999);
        chk("pre_wrap_ovf", 32'(overflow), 32'h0);
        cyc(3);                                   // E40194
        chk("wrap_ovf", 32'(overflow), 32'h1);
        chk("wrap_tick", 32'(tick), 32'h1);
        cyc(1);                                   // E40195
        chk("wrap_num", 32'(number), 32'h0000);
        cyc(8);                                   // E40203
        chk("ovf_sticky_num", 32'(number), 32'h0002);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        // PAUSE lands on a tick edge (E40206): that increment still applies.
        press(1'b1, 1'b0, 1'b0);                  // E40206
        chk("pause_tick_edge", 32'(tick), 32'h1);
        chk("pause_ovf_kept", 32'(overflow), 32'h1);
        cyc(1);                                   // E40207
        chk("pause_edge_num", 32'(number), 32'h0003);
        press(1'b0, 1'b1, 1'b0);                  // E40210
        chk("clr_ovf", 32'(overflow), 32'h0);
        cyc(1);                                   // E40211
        chk("clr2_num", 32'(number), 32'h0);

        // Mid-cycle asynchronous reset while running.
        press(1'b1, 1'b0, 1'b0);                  // E40214
        cyc(10);                                  // E40224
        chk("rerun_num", 32'(number), 32'h0002);
        #4 rst_n = 1'b0;
        #1;
        chk("async_num", 32'(number), 32'h0);
        chk("async_running", 32'(running), 32'h0);
        chk("async_ovf", 32'(overflow), 32'h0);
        chk("async_dots", 32'(dots), 32'h4);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Controller that sequences a clock-enable-driven decimal counter as a stopwatch.
- Owns a tick prescaler and a BCD digit counter.
- Takes start/stop, clear and lap key presses and runs a control FSM (IDLE/RUN/LAP/PAUSE).
- Drives the number/dots inputs of the existing seven_segment_display in lab_top, replacing the free-running slow counter.

Parameters:
- clk_mhz, 50, board clock frequency in MHz (informational; sets the tick_div default).
- w_digit, 8, number of BCD digits (4 bits each) on number.
- tick_div, clk_mhz*10000, clk cycles per count tick (default = 10 ms, so the lowest digit counts hundredths); must be >= 2.
- dot_pos, 2, digit index whose dot is lit; no dot is lit if dot_pos >= w_digit.

Ports:
- clk  input  1  system clock; all flops on posedge.
- rst_n  input  1  asynchronous active-low reset.
- key_ss  input  1  start/stop key, level, asynchronous to clk.
- key_clr  input  1  clear key, level, asynchronous.
- key_lap  input  1  lap key, level, asynchronous.
- number  output  4*w_digit  BCD value to display, digit 0 = least significant nibble.
- dots  output  w_digit  dot enables; constant one-hot at dot_pos.
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP (display frozen).
- tick  output  1  one-cycle pulse on each counter increment.
- overflow  output  1  sticky; set when the counter wraps from all-9s to 0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; prescaler=0; all BCD digits=0; lap snapshot=0; sync/edge flops=0; number=0; running=0; lap_active=0; tick=0; overflow=0. dots is constant and is not affected by reset.
- Key inputs: each passes through a 2-flop synchronizer plus a previous-value flop. press = sync2 & ~prev, a single-cycle pulse per rising level. No debounce; the bench drives clean levels.
- Latency: a key rising before edge k causes the state change on edge k+2. Held keys produce one press only.
- FSM transitions (evaluated on press pulses; at most one transition per cycle):
  - IDLE: ss -> RUN, prescaler cleared to 0. clr and lap are ignored.
  - RUN: ss -> PAUSE. Otherwise lap -> LAP, snapshot <= live count on the same edge. clr is ignored.
  - LAP: ss -> PAUSE, display returns to the live count. Otherwise lap -> RUN, display returns to live. clr is ignored.
  - PAUSE: ss -> RUN, prescaler resumes from its held value. Otherwise clr -> IDLE: BCD=0, prescaler=0, overflow=0, snapshot=0.
  - Simultaneous presses: priority ss > clr > lap; lower-priority presses in the same cycle are dropped.
- Prescaler:
  - Counts only in RUN/LAP and holds in IDLE/PAUSE.
  - At value tick_div-1 it wraps to 0 and tick=1 for that cycle, registered so that tick is high the cycle after the wrap edge.
  - The BCD increment occurs on the wrap edge.
  - Width is $clog2(tick_div).
- BCD counter:
  - Digit 0 increments per tick.
  - A digit at 9 wraps to 0 and carries into the next digit.
  - All digits at 9 plus a tick gives all 0 and overflow <= 1; overflow stays set until clr in PAUSE, or reset.
  - Digits never take values 10-15.
- number (registered, one-cycle lag from its source): snapshot while in LAP, otherwise the live count. The live count keeps advancing while in LAP.
- Entering PAUSE from LAP on a tick edge: the tick increment still applies.
- State, prescaler and counters are updated in the same always_ff. There are no combinational paths from key inputs to outputs.

Test Plan (tick_div=4, w_digit=4, dot_pos=2):
- Reset → IDLE: assert rst_n=0 mid-cycle -> number=0, running=0, overflow=0 immediately. dots=4'b0100 at all times.
- Start and count: key_ss pulse -> running=1 three edges after assertion. tick is asserted every 4 cycles. After 40 cycles in RUN, number=16'h0010. Holding key_ss high for 20 cycles does not stop the counter.
- Lap freeze: at number=0x0007 press key_lap -> lap_active=1 and number stays 0x0007 while the live count runs. After 12 more cycles press key_lap -> number shows the live value ≈0x000A, lap_active=0.
- Pause/clear: press ss -> running=0, number holds and tick stays 0 for 100 cycles. Press clr -> number=0, state IDLE. clr pressed during RUN -> no effect.
- Simultaneous presses: ss+clr in the same cycle while in PAUSE -> RUN, counter not cleared. ss+lap in the same cycle while in RUN -> PAUSE, lap_active=0.
- Wrap: preload via 9999 ticks (or force) to 0x9999, one more tick -> number=0x0000, overflow=1. overflow persists through further counting and clears only via PAUSE+clr.
